// File: rtl/sync_fifo_ctrl_if.sv
// User-side push/pop and status bundle for sync_fifo_ctrl.
// The master drives requests (client), the slave is the controller.
interface sync_fifo_ctrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  ready;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   count;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, ready, full, empty, almost_full, count
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, ready, full, empty, almost_full, count
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// FIFO controller in front of an external dp_sram: pointers, occupancy, flags, RAM strobes.
// Optional sticky overflow/underflow flags when FIFO_CTRL_ERR_FLAGS_EN is defined.
module sync_fifo_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int AFULL_TH   = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sync_fifo_ctrl_if.slave       fifo,
   output logic                  ram_csen_n,
   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic                  ram_wrena_n,
   output logic [DATA_WIDTH-1:0] ram_dina,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   output logic                  ram_rdenb_n,
   input  logic [DATA_WIDTH-1:0] ram_doutb
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   ,
   output logic                  err_ovf,
   output logic                  err_udf
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_ready;
   logic             w_csen_n;

   logic [CNT_W-1:0] r_wptr;
   logic [CNT_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic             r_afull;
   logic             r_rd_valid;
   logic             w_wa;
   logic             w_ra;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_csen_n    = 1'b1;
      case (r_state)
         ST_INIT: w_state_nxt = ST_RUN;
         ST_RUN: begin
            w_ready  = 1'b1;
            w_csen_n = 1'b0;
         end
      endcase
   end

   // Flags are registered, so they already block a same-cycle write-through at full/empty.
   assign w_wa = w_ready & fifo.wr_en & ~r_full  & ~fifo.flush;
   assign w_ra = w_ready & fifo.rd_en & ~r_empty & ~fifo.flush;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wa, w_ra})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
      if (fifo.flush) w_count_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_afull    <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         if (fifo.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wa) r_wptr <= r_wptr + CNT_W'(1);
            if (w_ra) r_rptr <= r_rptr + CNT_W'(1);
         end
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty    <= (w_count_nxt == '0);
         r_afull    <= (w_count_nxt >= CNT_W'(AFULL_TH));
         // A pop accepted just before a flush still returns its word.
         r_rd_valid <= w_ra;
      end
   end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else if (fifo.flush) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (fifo.wr_en & r_full  & w_ready) err_ovf <= 1'b1;
         if (fifo.rd_en & r_empty & w_ready) err_udf <= 1'b1;
      end
   end
`endif

   assign ram_csen_n       = w_csen_n;
   assign ram_wrena_n      = ~w_wa;
   assign ram_addra        = r_wptr[ADDR_WIDTH-1:0];
   assign ram_dina         = fifo.wr_data;
   assign ram_rdenb_n      = ~w_ra;
   assign ram_addrb        = r_rptr[ADDR_WIDTH-1:0];

   assign fifo.rd_data     = ram_doutb;
   assign fifo.rd_valid    = r_rd_valid;
   assign fifo.ready       = w_ready;
   assign fifo.full        = r_full;
   assign fifo.empty       = r_empty;
   assign fifo.almost_full = r_afull;
   assign fifo.count       = r_count;

endmodule
